// File: rtl/sparse_pkg.sv
// Shared definitions for the sparse dot-product engine: default sizing,
// the control state encoding and the width rule for the optional
// pair counter (enabled with SPARSE_STATS_EN).
package sparse_pkg;

  localparam int DEF_N     = 16;
  localparam int DEF_W     = 8;
  localparam int DEF_ACC_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width of the multiplied-pair counter for an N-element engine.
  function automatic int nnz_width(input int n);
    return $clog2(n * 256) + 1;
  endfunction

endpackage

// File: rtl/sparse_dot_engine_nz_pri_enc.sv
// Lowest-set-bit priority encoder: returns the index of the lowest set
// bit of the mask and whether any bit is set at all.
module nz_pri_enc #(
  parameter int N = 16,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  mask,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = i[IW-1:0];
        any = 1'b1;
      end else begin
        idx = idx;
      end
    end
  end

endmodule

// File: rtl/sparse_dot_engine.sv
// Sparse dot-product engine. Each accepted beat registers two packed
// vectors, marks the element positions where both operands are nonzero,
// then multiplies and accumulates one marked pair per cycle (lowest index
// first) plus one closing cycle. A beat flagged last presents the result,
// which is held until the consumer takes it. Accumulation wraps at ACC_W
// bits with a sticky carry-out flag.
// Optional feature: define SPARSE_STATS_EN to add out_nnz, the count of
// multiplied pairs contributing to the presented result.
module sparse_dot_engine
  import sparse_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int W     = DEF_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*W-1:0]     Vector_A,
  input  logic [N*W-1:0]     Vector_B,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_Final,
`ifdef SPARSE_STATS_EN
  output logic [nnz_width(N)-1:0] out_nnz,
`endif
  output logic               out_ovf
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  // Sum is wide enough to hold either operand plus one carry bit.
  localparam int SW = ((ACC_W > 2 * W) ? ACC_W : 2 * W) + 1;

  state_t           state;
  state_t           state_next;
  logic [N*W-1:0]   a_reg;
  logic [N*W-1:0]   b_reg;
  logic             last_reg;
  logic [N-1:0]     mask;
  logic [N-1:0]     nz_mask;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic [IW-1:0]    pe_idx;
  logic             pe_any;
  logic [2*W-1:0]   prod;
  logic [SW-1:0]    sum;
  logic             carry;

  nz_pri_enc #(.N(N), .IW(IW)) u_pri_enc (
    .mask (mask),
    .idx  (pe_idx),
    .any  (pe_any)
  );

  // Positions where both incoming operands are nonzero qualify for a multiply.
  always_comb begin
    nz_mask = '0;
    for (int i = 0; i < N; i++) begin
      nz_mask[i] = (|Vector_A[i*W +: W]) && (|Vector_B[i*W +: W]);
    end
  end

  // Multiply the selected pair and add it to the accumulator with a carry-out.
  always_comb begin
    prod  = a_reg[pe_idx*W +: W] * b_reg[pe_idx*W +: W];
    sum   = SW'(acc) + SW'(prod);
    carry = |sum[SW-1:ACC_W];
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: accept, drain the mask, then close or wait for more.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          state_next = ST_SCAN;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (!pe_any) begin
          state_next = last_reg ? ST_DONE : ST_IDLE;
        end else begin
          state_next = ST_SCAN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Operand capture, per-pair accumulation and result release.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      last_reg <= 1'b0;
      mask     <= '0;
      acc      <= '0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_reg    <= Vector_A;
            b_reg    <= Vector_B;
            last_reg <= in_last;
            mask     <= nz_mask;
          end
        end
        ST_SCAN: begin
          if (pe_any) begin
            acc          <= sum[ACC_W-1:0];
            ovf          <= ovf | carry;
            mask[pe_idx] <= 1'b0;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            acc <= '0;
            ovf <= 1'b0;
          end
        end
        default: begin
          mask <= '0;
        end
      endcase
    end
  end

`ifdef SPARSE_STATS_EN
  localparam int NNZ_W = nnz_width(N);
  logic [NNZ_W-1:0] nnz;

  // Count multiplied pairs; cleared together with the accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      nnz <= '0;
    end else if (state == ST_SCAN && pe_any) begin
      nnz <= nnz + {{(NNZ_W-1){1'b0}}, 1'b1};
    end else if (state == ST_DONE && out_ready) begin
      nnz <= '0;
    end
  end

  assign out_nnz = nnz;
`endif

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign out_Final = acc;
  assign out_ovf   = ovf;

endmodule

// File: tb/tb_sparse_dot_engine.sv
// Directed bench for sparse_dot_engine. Two instances run in lockstep on the
// same stimulus: default sizing (ACC_W=24) and a narrow accumulator
// (ACC_W=16) to exercise wraparound. A plain arithmetic model of the dot
// product is checked by a negedge monitor whenever the result is observable.
module tb_sparse_dot_engine;

  localparam int N = 16;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic [N*W-1:0] va;
  logic [N*W-1:0] vb;
  logic in_last;
  logic out_ready;

  logic in_ready0, out_valid0, out_ovf0;
  logic in_ready1, out_valid1, out_ovf1;
  logic [23:0] out_final0;
  logic [15:0] out_final1;
`ifdef SPARSE_STATS_EN
  logic [12:0] out_nnz0;
  logic [12:0] out_nnz1;
`endif

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;

  // Model state: exact unbounded dot product and pair count of the pending result.
  longint exp_sum = 0;
  int     exp_pairs = 0;

  always #5 clk = ~clk;

  sparse_dot_engine #(.N(N), .W(W), .ACC_W(24)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .Vector_A(va), .Vector_B(vb), .in_last(in_last),
    .out_valid(out_valid0), .out_ready(out_ready), .out_Final(out_final0),
`ifdef SPARSE_STATS_EN
    .out_nnz(out_nnz0),
`endif
    .out_ovf(out_ovf0)
  );

  sparse_dot_engine #(.N(N), .W(W), .ACC_W(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .Vector_A(va), .Vector_B(vb), .in_last(in_last),
    .out_valid(out_valid1), .out_ready(out_ready), .out_Final(out_final1),
`ifdef SPARSE_STATS_EN
    .out_nnz(out_nnz1),
`endif
    .out_ovf(out_ovf1)
  );

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: result observable in IDLE/DONE must match the model.
  always @(negedge clk) begin
    if (mon_en) begin
      if (in_ready0 || out_valid0) begin
        check("mon_final24", longint'(out_final0), exp_sum % 64'd16777216);
        check("mon_rdy_vld_excl0", longint'(in_ready0 & out_valid0), 0);
      end
      if (in_ready1 || out_valid1) begin
        check("mon_final16", longint'(out_final1), exp_sum % 64'd65536);
      end
      check("mon_lockstep", longint'({in_ready1, out_valid1}), longint'({in_ready0, out_valid0}));
      if (out_valid0) begin
        check("mon_ovf24", longint'(out_ovf0), longint'(exp_sum >= 64'd16777216));
`ifdef SPARSE_STATS_EN
        check("mon_nnz24", longint'(out_nnz0), longint'(exp_pairs));
`endif
      end
      if (out_valid1) begin
        check("mon_ovf16", longint'(out_ovf1), longint'(exp_sum >= 64'd65536));
`ifdef SPARSE_STATS_EN
        check("mon_nnz16", longint'(out_nnz1), longint'(exp_pairs));
`endif
      end
    end
  end

  // Present one beat once the engine is idle; update the model on acceptance.
  task automatic start_beat(input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                            input logic last, output int pairs);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready0 && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 200) check("wait_in_ready", 0, 1);
    va = a; vb = b; in_last = last; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    va = '1; vb = '1; in_last = 1'b0;
    pairs = 0;
    for (int i = 0; i < N; i++) begin
      if (a[i*W +: W] != 0 && b[i*W +: W] != 0) begin
        exp_sum += longint'(a[i*W +: W]) * longint'(b[i*W +: W]);
        pairs++;
      end
    end
    exp_pairs += pairs;
  endtask

  // Full beat: accept, then count SCAN cycles and compare with pairs+1.
  task automatic send_beat(input string name, input logic [N*W-1:0] a,
                           input logic [N*W-1:0] b, input logic last);
    int pairs;
    int scan;
    start_beat(a, b, last, pairs);
    scan = 0;
    @(negedge clk);
    while (!(in_ready0 || out_valid0) && scan < 200) begin
      scan++;
      @(negedge clk);
    end
    check({name, "_scan_cycles"}, scan, pairs + 1);
    check({name, "_done_state"}, longint'(out_valid0), longint'(last));
  endtask

  // Take the result and confirm the return to IDLE on the next cycle.
  task automatic consume(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    exp_sum = 0;
    exp_pairs = 0;
    check({name, "_rel_in_ready"}, longint'(in_ready0), 1);
    check({name, "_rel_out_valid"}, longint'(out_valid0), 0);
    check({name, "_rel_final"}, longint'(out_final0), 0);
    check({name, "_rel_ovf16"}, longint'(out_ovf1), 0);
  endtask

  function automatic logic [N*W-1:0] fill(input logic [W-1:0] v);
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = v;
    return r;
  endfunction

  initial begin
    logic [N*W-1:0] a;
    logic [N*W-1:0] b;
    logic [23:0] held0;
    logic [15:0] held1;
    int pairs;

    rst = 1'b1; in_valid = 1'b0; va = '0; vb = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", longint'(in_ready0), 1);
    check("rst_out_valid", longint'(out_valid0), 0);
    check("rst_final24", longint'(out_final0), 0);
    check("rst_ovf24", longint'(out_ovf0), 0);
    check("rst_final16", longint'(out_final1), 0);
    mon_en = 1'b1;

    // All-ones vectors: 16 pairs, 17 SCAN cycles, result 16.
    send_beat("ones", fill(8'd1), fill(8'd1), 1'b1);
    check("ones_lit", longint'(out_final0), 16);
    consume("ones");

    // All-zero A: one SCAN cycle, zero result.
    send_beat("zeroA", fill(8'd0), fill(8'd9), 1'b1);
    check("zeroA_lit", longint'(out_final0), 0);
    check("zeroA_ovf", longint'(out_ovf0), 0);
    consume("zeroA");

    // Two-beat accumulation: 5*7 + 2*10 = 55.
    a = '0; b = '0; a[3*W +: W] = 8'd5; b[3*W +: W] = 8'd7;
    send_beat("two_b1", a, b, 1'b0);
    a = '0; b = '0; a[0 +: W] = 8'd2; b[0 +: W] = 8'd10;
    send_beat("two_b2", a, b, 1'b1);
    check("two_model_lit", exp_sum, 55);
    check("two_lit24", longint'(out_final0), 55);
    check("two_lit16", longint'(out_final1), 55);
    consume("two");

    // Saturated operands: 16*65025 wraps to 57360 on the 16-bit instance.
    send_beat("sat", fill(8'd255), fill(8'd255), 1'b1);
    check("sat_model_lit", exp_sum, 1040400);
    check("sat_lit16", longint'(out_final1), 57360);
    check("sat_ovf16", longint'(out_ovf1), 1);
    check("sat_lit24", longint'(out_final0), 1040400);
    check("sat_ovf24", longint'(out_ovf0), 0);

    // Back-pressure: hold the result for 5 cycles.
    held0 = out_final0;
    held1 = out_final1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_final24", longint'(out_final0), longint'(held0));
      check("hold_final16", longint'(out_final1), longint'(held1));
      check("hold_ovf16", longint'(out_ovf1), 1);
      check("hold_in_ready", longint'(in_ready0), 0);
    end
    consume("hold");

    // Reset in the middle of a scan discards the partial result.
    start_beat(fill(8'd1), fill(8'd1), 1'b1, pairs);
    repeat (5) @(negedge clk);
    check("midscan_busy", longint'(in_ready0 | out_valid0), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_sum = 0;
    exp_pairs = 0;
    check("midrst_in_ready", longint'(in_ready0), 1);
    check("midrst_out_valid", longint'(out_valid0), 0);
    check("midrst_final24", longint'(out_final0), 0);
    check("midrst_final16", longint'(out_final1), 0);

    // Independent beat after reset: A_i=i, B_i=3 on even i -> 3*56 = 168.
    for (int i = 0; i < N; i++) begin
      a[i*W +: W] = W'(i);
      b[i*W +: W] = (i % 2 == 0) ? 8'd3 : 8'd0;
    end
    send_beat("post_rst", a, b, 1'b1);
    check("post_rst_lit", longint'(out_final0), 168);
    consume("post_rst");

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sparse_dot_engine.md
SPARSE_DOT_ENGINE -- requirements
Module: sparse_dot_engine

Interface
REQ-001 SHALL have parameter N, default 16, number of elements per input vector.
REQ-002 SHALL have parameter W, default 8, unsigned element width in bits.
REQ-003 SHALL have parameter ACC_W, default 24, accumulator and result width.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  input beat valid.
REQ-007 SHALL have port in_ready  output  1  engine accepts a beat.
REQ-008 SHALL have port Vector_A  input  N*W  packed operand A, element i at bits [i*W +: W].
REQ-009 SHALL have port Vector_B  input  N*W  packed operand B, same packing.
REQ-010 SHALL have port in_last  input  1  beat closes the current accumulation.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-013 SHALL have port out_Final  output  ACC_W  accumulated dot product.
REQ-014 SHALL have port out_ovf  output  1  sticky overflow flag for the current result.

Function
REQ-015 SHALL implement states IDLE, SCAN and DONE; in_ready = (state==IDLE), out_valid = (state==DONE).
REQ-016 SHALL, in IDLE, on in_valid&&in_ready, register A, B and in_last, store mask[i] = (A_i!=0)&&(B_i!=0), and go to SCAN.
REQ-017 SHALL, in each SCAN cycle with mask!=0, select the lowest set index k, add A_k*B_k (2W-bit unsigned) to the accumulator, and clear mask[k].
REQ-018 SHALL, in a SCAN cycle with mask==0, go to DONE if the registered last is 1, otherwise return to IDLE with the accumulator retained.
REQ-019 SHALL take p+1 SCAN cycles for a beat with p qualifying pairs, so an all-zero beat costs exactly 1 SCAN cycle.
REQ-020 SHALL compute the accumulator modulo 2^ACC_W and set out_ovf when any add carries out of ACC_W bits; out_ovf stays set until the result is consumed.
REQ-021 SHALL hold out_Final and out_ovf stable in DONE until out_valid&&out_ready.
REQ-022 SHALL, on the DONE handshake, clear the accumulator and out_ovf and go to IDLE; in_ready rises the next cycle.
REQ-023 SHALL ignore in_valid outside IDLE; input data is sampled only on the accept edge.
REQ-024 SHALL drive out_Final from the accumulator register (0 latency from the last add to DONE entry plus 1 cycle).

Reset
REQ-025 SHALL, on rst high at a clock edge, enter IDLE with accumulator=0, mask=0, out_Final=0, out_ovf=0, out_valid=0, in_ready=1 on the following cycle.
REQ-026 SHALL give rst priority over every handshake; rst mid-SCAN or in DONE discards the partial or pending result.

Configuration
REQ-027 SHALL, with SPARSE_STATS_EN defined, add output out_nnz (clog2(N*256)+1 bits) holding the number of multiplied pairs in the result; it is cleared with the accumulator and valid with out_valid.
REQ-028 SHALL, without SPARSE_STATS_EN, omit out_nnz and its counter, with all other behaviour identical.

Structure
REQ-029 SHALL place the state enum and the default N/W/ACC_W constants in shared package sparse_pkg.
REQ-030 SHALL implement lowest-set-bit selection in sub-module nz_pri_enc (N-bit mask in, index and any-set out).

Verification
REQ-031 SHALL cover: N=16, W=8, one beat, A_i=B_i=1 for all i, last=1 -> DONE after 17 SCAN cycles, out_Final=16.
REQ-032 SHALL cover: an all-zero A beat with last=1 -> 1 SCAN cycle, out_Final=0, out_ovf=0.
REQ-033 SHALL cover: beat 1 with A_3=5, B_3=7, last=0, then beat 2 with A_0=2, B_0=10, last=1 -> out_Final=55.
REQ-034 SHALL cover: ACC_W=16, all A_i=B_i=255, last=1 -> out_ovf=1 and out_Final=(16*65025) mod 65536=57360.
REQ-035 SHALL cover: out_ready held low for 5 cycles in DONE -> out_Final stable and in_ready=0 throughout; release -> IDLE the next cycle.
REQ-036 SHALL cover: rst asserted mid-SCAN -> IDLE next cycle with out_Final=0, and the following beat computes independently.
